// File: rtl/alu_divider_pkg.sv
// Shared types and constants for the DIV/DIVU multi-cycle divider.
// Holds the FSM state enum, the result bundle and the operand-width constants.
package alu_divider_pkg;

    localparam int DIV_W_WIDE = 16;
    localparam int DIV_W_BYTE = 8;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_SETUP,
        DIV_ITER,
        DIV_FIXUP,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic [15:0] quotient;
        logic [15:0] remainder;
        logic        error;
    } div_result_t;

    // Byte-mode results are zero-extended, so only the low byte survives.
    function automatic logic [15:0] div_width_mask(input logic wide);
        return wide ? 16'hFFFF : 16'h00FF;
    endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module alu_divider_div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0] w_trial;

    assign w_trial = {i_rem, i_bit};
    assign o_qbit  = (w_trial >= {1'b0, i_divisor});
    // The partial remainder stays below the divisor, so the difference fits in W bits.
    assign o_rem   = o_qbit ? (w_trial[W-1:0] - i_divisor) : w_trial[W-1:0];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle signed/unsigned divider (DIV/DIVU) for 32/16 and 16/8 operands.
// Optional macro DIV_EARLY_OUT_EN leaves ITER early once the remaining work is all zero.
//
// state     | meaning
// DIV_IDLE  | waiting for start; operands latched on acceptance
// DIV_SETUP | take magnitudes, detect divide-by-zero / overflow
// DIV_ITER  | restoring division, BITS_PER_CYCLE quotient bits per cycle
// DIV_FIXUP | apply signs, check signed quotient range
// DIV_DONE  | done pulse; results presented
module alu_divider
    import alu_divider_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_signed_op,
    input  logic        i_wide,
    input  logic [31:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_div_error,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder
);

    localparam logic [4:0] C_BPC = 5'(BITS_PER_CYCLE);

    div_state_e  r_state;
    logic        r_signed_op;
    logic        r_wide;
    logic [31:0] r_dividend;
    logic [15:0] r_divisor;
    logic [15:0] r_dsr_mag;
    logic [15:0] r_rem;
    logic [15:0] r_dvd_lo;
    logic [15:0] r_quo;
    logic [4:0]  r_cnt;

    logic        w_dvd_neg;
    logic        w_dsr_neg;
    logic [31:0] w_dvd_abs32;
    logic [15:0] w_dvd_abs16;
    logic [15:0] w_dsr_abs16;
    logic [7:0]  w_dsr_abs8;
    logic [15:0] w_dsr_mag;
    logic [15:0] w_dvd_hi;
    logic [15:0] w_dvd_lo;
    logic        w_setup_err;
    logic [4:0]  w_n;

    logic                      w_q_neg;
    logic [15:0]               w_limit;
    logic [15:0]               w_mask;
    logic [15:0]               w_q_sgn;
    logic [15:0]               w_r_sgn;
    div_result_t               w_fix;

    logic [BITS_PER_CYCLE-1:0] w_qbits;
    logic [15:0]               w_rem_next;
    logic [15:0]               w_quo_next;
    logic [15:0]               w_dvd_shift;

    assign w_n = r_wide ? 5'(DIV_W_WIDE) : 5'(DIV_W_BYTE);

    // Operand magnitudes; byte-mode dividend bits are left-aligned so ITER always consumes bit 15.
    always_comb begin
        w_dvd_neg   = r_signed_op & (r_wide ? r_dividend[31] : r_dividend[15]);
        w_dsr_neg   = r_signed_op & (r_wide ? r_divisor[15] : r_divisor[7]);
        w_dvd_abs32 = w_dvd_neg ? (32'd0 - r_dividend) : r_dividend;
        w_dvd_abs16 = w_dvd_neg ? (16'd0 - r_dividend[15:0]) : r_dividend[15:0];
        w_dsr_abs16 = w_dsr_neg ? (16'd0 - r_divisor) : r_divisor;
        w_dsr_abs8  = w_dsr_neg ? (8'd0 - r_divisor[7:0]) : r_divisor[7:0];
        if (r_wide) begin
            w_dsr_mag = w_dsr_abs16;
            w_dvd_hi  = w_dvd_abs32[31:16];
            w_dvd_lo  = w_dvd_abs32[15:0];
        end else begin
            w_dsr_mag = {8'h00, w_dsr_abs8};
            w_dvd_hi  = {8'h00, w_dvd_abs16[15:8]};
            w_dvd_lo  = {w_dvd_abs16[7:0], 8'h00};
        end
        w_setup_err = (w_dsr_mag == 16'h0000) || (w_dvd_hi >= w_dsr_mag);
    end

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        logic [15:0] w_rem_in;
        logic [15:0] w_rem_out;
        logic        w_qbit;

        if (g == 0) begin : g_first
            assign w_rem_in = r_rem;
        end else begin : g_next
            assign w_rem_in = g_step[g-1].w_rem_out;
        end

        alu_divider_div_step #(
            .W(16)
        ) u_step (
            .i_rem     (w_rem_in),
            .i_bit     (r_dvd_lo[15-g]),
            .i_divisor (r_dsr_mag),
            .o_rem     (w_rem_out),
            .o_qbit    (w_qbit)
        );

        assign w_qbits[BITS_PER_CYCLE-1-g] = w_qbit;
    end

    assign w_rem_next  = g_step[BITS_PER_CYCLE-1].w_rem_out;
    assign w_quo_next  = {r_quo[15-BITS_PER_CYCLE:0], w_qbits};
    assign w_dvd_shift = r_dvd_lo << BITS_PER_CYCLE;

    // Signed fixup: a negative quotient may reach -2^(N-1), a positive one only 2^(N-1)-1.
    always_comb begin
        w_q_neg         = w_dvd_neg ^ w_dsr_neg;
        w_limit         = r_wide ? 16'h8000 : 16'h0080;
        w_mask          = div_width_mask(r_wide);
        w_q_sgn         = w_q_neg ? (16'h0000 - r_quo) : r_quo;
        w_r_sgn         = w_dvd_neg ? (16'h0000 - r_rem) : r_rem;
        w_fix.error     = r_signed_op && (w_q_neg ? (r_quo > w_limit) : (r_quo >= w_limit));
        w_fix.quotient  = w_fix.error ? 16'h0000 : (w_q_sgn & w_mask);
        w_fix.remainder = w_fix.error ? 16'h0000 : (w_r_sgn & w_mask);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= DIV_IDLE;
            r_signed_op <= 1'b0;
            r_wide      <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_dsr_mag   <= '0;
            r_rem       <= '0;
            r_dvd_lo    <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_div_error <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_start) begin
                        r_signed_op <= i_signed_op;
                        r_wide      <= i_wide;
                        r_dividend  <= i_dividend;
                        r_divisor   <= i_divisor;
                        o_busy      <= 1'b1;
                        r_state     <= DIV_SETUP;
                    end
                end
                DIV_SETUP: begin
                    r_dsr_mag <= w_dsr_mag;
                    r_rem     <= w_dvd_hi;
                    r_dvd_lo  <= w_dvd_lo;
                    r_quo     <= '0;
                    r_cnt     <= w_n;
                    if (w_setup_err) begin
                        o_div_error <= 1'b1;
                        o_quotient  <= '0;
                        o_remainder <= '0;
                        o_done      <= 1'b1;
                        r_state     <= DIV_DONE;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if ((w_dvd_hi == 16'h0000) && (w_dvd_lo == 16'h0000)) begin
                        r_state <= DIV_FIXUP;
                    end
`endif
                    else begin
                        r_state <= DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    r_rem    <= w_rem_next;
                    r_dvd_lo <= w_dvd_shift;
                    r_cnt    <= r_cnt - C_BPC;
                    if (r_cnt == C_BPC) begin
                        r_quo   <= w_quo_next;
                        r_state <= DIV_FIXUP;
                    end
`ifdef DIV_EARLY_OUT_EN
                    // Remaining quotient bits are all zero; just align what we have.
                    else if ((w_rem_next == 16'h0000) && (w_dvd_shift == 16'h0000)) begin
                        r_quo   <= w_quo_next << (r_cnt - C_BPC);
                        r_state <= DIV_FIXUP;
                    end
`endif
                    else begin
                        r_quo <= w_quo_next;
                    end
                end
                DIV_FIXUP: begin
                    o_div_error <= w_fix.error;
                    o_quotient  <= w_fix.quotient;
                    o_remainder <= w_fix.remainder;
                    o_done      <= 1'b1;
                    r_state     <= DIV_DONE;
                end
                DIV_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule
